// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit for the rv32i core.
//
// Takes the ALU result as the effective address and runs one data-memory
// transaction per instruction over a req/ack bus. Returns a sign- or
// zero-extended load result, flags misaligned accesses and illegal funct3,
// aborts with bus_err when memory does not answer within TIMEOUT cycles,
// and holds busy so the core stalls while an access is pending.
//
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   start              one-cycle launch pulse for the op_* / addr / data inputs
//   op_load, op_store  access type (both high is treated as a load)
//   funct3             RV32I width/sign encoding
//   addr, store_data   effective address and rs2 value
//   busy, done         stall request and one-cycle completion pulse
//   load_data          extended load result (0 on error)
//   misaligned,bus_err completion status, valid with done
//   mem_*              data-memory request bus (req held until mem_ack)
module rv32i_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_load,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic        launch;
    logic        is_load;
    logic [1:0]  size;
    logic        illegal;
    logic        misal;
    logic        timeout_hit;
    logic [3:0]  strb_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    // Both strobes high decodes as a load.
    assign is_load = op_load;
    assign size    = funct3[1:0];
    assign launch  = (state == IDLE) && start && (op_load || op_store);

    // Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
    assign illegal = (size == 2'b11) ||
                     (is_load  && funct3 == 3'b110) ||
                     (!is_load && funct3[2]);

    // Alignment only matters for an encoding that names a real size.
    assign misal = !illegal &&
                   ((size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00));

    // Ack in the final cycle takes precedence over the abort.
    assign timeout_hit = (TIMEOUT > 0) && !mem_ack &&
                         (tmo_cnt == CW'(TIMEOUT - 1));

    assign busy    = (state != IDLE) || launch;
    assign done    = (state == RESP);
    assign mem_req = (state == ACCESS);

    // Byte enables and lane-replicated store data for the access being launched.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        strb_nxt  = 4'b1111;
        wdata_nxt = store_data;
        case (size)
            2'b00: begin
                wdata_nxt = {4{store_data[7:0]}};
                if (!is_load) strb_nxt = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_nxt = {2{store_data[15:0]}};
                if (!is_load) strb_nxt = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Lane select and extension of the returned word.
    always_comb begin
        rd_byte  = mem_rdata[7:0];
        rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_data = 32'h0;
        case (off_q)
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        case (f3_q)
            3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ext_data = mem_rdata;
            3'b100:  ext_data = {24'h0, rd_byte};
            3'b101:  ext_data = {16'h0, rd_half};
            default: ext_data = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = (illegal || misal) ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt    <= '0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        tmo_cnt    <= '0;
                        f3_q       <= funct3;
                        off_q      <= addr[1:0];
                        load_data  <= 32'h0;
                        misaligned <= misal;
                        bus_err    <= illegal;
                        mem_we     <= !is_load;
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_wstrb  <= strb_nxt;
                        mem_wdata  <= wdata_nxt;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we) load_data <= ext_data;
                    end else if (timeout_hit) begin
                        bus_err <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed testbench for rv32i_lsu: a table of hand-computed accesses applied
// one after another, plus a hand-written reset-during-access sequence.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_load;
    logic        op_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32i_lsu #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_load    (op_load),
        .op_store   (op_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    // ack_at: cycle (after start) in which mem_ack is pulsed, 0 = never.
    // req_cycles: mem_req expected high in cycles 1..req_cycles.
    // done_at: cycle of the done pulse.
    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_at;
        int          req_cycles;
        int          done_at;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] ld_data;
        logic        mis;
        logic        err;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    got_done;
        string tag;
        got_done = -1;
        tag = $sformatf("v%0d", idx);

        @(posedge clk); #1;
        start = 1'b1; op_load = v.ld; op_store = v.st; funct3 = v.f3;
        addr = v.addr; store_data = v.sd; mem_ack = 1'b0; mem_rdata = v.rdata;
        @(negedge clk);
        check({tag, " busy_start"}, {31'h0, busy}, 32'h1);
        check({tag, " req_start"}, {31'h0, mem_req}, 32'h0);

        for (int c = 1; c <= 40 && got_done < 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0; op_load = 1'b0; op_store = 1'b0;
            funct3 = 3'b111; addr = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF;
            mem_ack = (v.ack_at == c);
            @(negedge clk);
            if (done) got_done = c;
            check($sformatf("%s req c%0d", tag, c), {31'h0, mem_req},
                  {31'h0, (c <= v.req_cycles)});
            check($sformatf("%s busy c%0d", tag, c), {31'h0, busy}, 32'h1);
            if (c <= v.req_cycles) begin
                check($sformatf("%s we c%0d", tag, c), {31'h0, mem_we}, {31'h0, v.we});
                check($sformatf("%s addr c%0d", tag, c), mem_addr, v.maddr);
                check($sformatf("%s strb c%0d", tag, c), {28'h0, mem_wstrb}, {28'h0, v.strb});
                check($sformatf("%s wdata c%0d", tag, c), mem_wdata, v.wdata);
            end
        end
        check({tag, " done_cycle"}, 32'(got_done), 32'(v.done_at));
        check({tag, " load_data"}, load_data, v.ld_data);
        check({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, v.mis});
        check({tag, " bus_err"}, {31'h0, bus_err}, {31'h0, v.err});

        // One cycle later: pulse gone, unit idle, results still held.
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check({tag, " done_drop"}, {31'h0, done}, 32'h0);
        check({tag, " busy_drop"}, {31'h0, busy}, 32'h0);
        check({tag, " load_hold"}, load_data, v.ld_data);
        check({tag, " flags_hold"}, {30'h0, misaligned, bus_err}, {30'h0, v.mis, v.err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            ld st f3      addr          sd            rdata        ack req done we maddr        strb     wdata         ld_data       mis err
        vecs[0]  = '{1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0};
        vecs[1]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF0000, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0};
        vecs[2]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF0000, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'h00000080, 0, 0};
        vecs[3]  = '{1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF0000, 2,  2,  3, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFF80FF, 0, 0};
        vecs[4]  = '{1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF0000, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'h000080FF, 0, 0};
        vecs[5]  = '{1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h00007F00, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'h0000007F, 0, 0};
        vecs[6]  = '{1, 0, 3'b001, 32'h0000_0100, 32'h0,        32'h12348001, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFF8001, 0, 0};
        vecs[7]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 32'h0,        4,  4,  5, 1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0};
        vecs[8]  = '{0, 1, 3'b000, 32'h0000_0201, 32'h000000A5, 32'h0,        1,  1,  2, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0};
        vecs[9]  = '{0, 1, 3'b000, 32'h0000_0203, 32'h0000007E, 32'h0,        1,  1,  2, 1, 32'h200, 4'b1000, 32'h7E7E7E7E, 32'h0,        0, 0};
        vecs[10] = '{0, 1, 3'b010, 32'h0000_0300, 32'hCAFEF00D, 32'h0,        1,  1,  2, 1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0};
        vecs[11] = '{1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'hFFFFFFFF, 1,  0,  1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0};
        vecs[12] = '{0, 1, 3'b001, 32'h0000_0003, 32'h00001111, 32'h0,        0,  0,  1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0};
        vecs[13] = '{1, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0,  0,  1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 1};
        vecs[14] = '{0, 1, 3'b100, 32'h0000_0010, 32'h0,        32'h0,        0,  0,  1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 1};
        vecs[15] = '{1, 0, 3'b010, 32'h0000_0400, 32'h0,        32'hFFFFFFFF, 0,  16, 17, 0, 32'h400, 4'b1111, 32'h0,       32'h0,        0, 1};
        vecs[16] = '{1, 0, 3'b010, 32'h0000_0400, 32'h0,        32'h55AA55AA, 16, 16, 17, 0, 32'h400, 4'b1111, 32'h0,       32'h55AA55AA, 0, 0};
        vecs[17] = '{1, 1, 3'b010, 32'h0000_0100, 32'h0,        32'h13579BDF, 1,  1,  2, 0, 32'h100, 4'b1111, 32'h0,        32'h13579BDF, 0, 0};

        rst = 1'b1; start = 1'b0; op_load = 1'b0; op_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst busy_done_req_we", {28'h0, busy, done, mem_req, mem_we}, 32'h0);
        check("rst flags", {30'h0, misaligned, bus_err}, 32'h0);
        check("rst load_data", load_data, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);

        // start with neither strobe is ignored.
        @(posedge clk); #1 start = 1'b1; addr = 32'h100; funct3 = 3'b010;
        @(negedge clk);
        check("nop busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("nop state", {30'h0, busy, mem_req}, 32'h0);

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an access: dropped without a done pulse.
        @(posedge clk); #1;
        start = 1'b1; op_load = 1'b1; op_store = 1'b0; funct3 = 3'b010;
        addr = 32'h500; mem_ack = 1'b0; mem_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        start = 1'b0; op_load = 1'b0;
        @(negedge clk);
        check("mid_rst req_before", {31'h0, mem_req}, 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst req", {31'h0, mem_req}, 32'h0);
        check("mid_rst busy", {31'h0, busy}, 32'h0);
        check("mid_rst done", {31'h0, done}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("mid_rst no_done c%0d", c), {30'h0, done, mem_req}, 32'h0);
        end
        run_vec(18, '{1, 0, 3'b010, 32'h0000_0600, 32'h0, 32'h2468ACE0, 2, 2, 3, 0,
                      32'h600, 4'b1111, 32'h0, 32'h2468ACE0, 0, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
